// File: rtl/i2s_encoder.sv
// I2S (Philips) transmitter: stereo PCM in over valid/ready, MSB-first SCK/WS/SD out.
// Bit clock is divided from sys_clk; one sample pair is buffered ahead of the pair on the wire.
module i2s_encoder #(
    parameter int DATAWIDTH = 24,
    parameter int SLOT_BITS = 32,
    parameter int SCLK_DIV  = 20
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 en,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATAWIDTH-1:0] s_l_data,
    input  logic [DATAWIDTH-1:0] s_r_data,
    output logic                 sck_o,
    output logic                 ws_o,
    output logic                 sd_o,
    output logic                 frame_start_o,
    output logic [15:0]          underrun_cnt
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int B_W        = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME_BITS - 1);
    localparam logic [B_W-1:0]   B_SLOT   = B_W'(SLOT_BITS);
    localparam logic [B_W-1:0]   WS_FIRST = B_W'(SLOT_BITS - 1);
    localparam logic [B_W-1:0]   WS_LAST  = B_W'(FRAME_BITS - 2);

    logic [DIV_W-1:0]     div_cnt, div_nxt;
    logic [B_W-1:0]       bit_idx, bit_nxt;
    logic [DATAWIDTH-1:0] act_l, act_r, act_l_nxt, act_r_nxt;
    logic [DATAWIDTH-1:0] pend_l, pend_r;
    logic                 pend_vld;

    logic                 fall_evt;
    logic                 load;
    logic                 accept;
    logic                 right_slot;
    logic [B_W-1:0]       slot_bit;
    logic [DATAWIDTH-1:0] slot_word;
    logic [DATAWIDTH-1:0] shifted;
    logic                 sd_nxt;
    logic                 ws_nxt;

    assign s_ready = !pend_vld;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        fall_evt  = en && (div_cnt == DIV_LAST);
        load      = fall_evt && (bit_idx == B_LAST);
        accept    = s_valid && !pend_vld;
        div_nxt   = div_cnt;
        bit_nxt   = bit_idx;
        act_l_nxt = act_l;
        act_r_nxt = act_r;

        if (!en) begin
            div_nxt = DIV_LAST;
            bit_nxt = B_LAST;
        end else if (fall_evt) begin
            div_nxt = '0;
            bit_nxt = (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;
        end else begin
            div_nxt = div_cnt + 1'b1;
        end

        // A load with nothing pending plays silence; data accepted in this same cycle waits a frame.
        if (load) begin
            if (pend_vld) begin
                act_l_nxt = pend_l;
                act_r_nxt = pend_r;
            end else begin
                act_l_nxt = '0;
                act_r_nxt = '0;
            end
        end

        // Shifting past the sample width yields zeros, which is exactly the slot padding.
        right_slot = (bit_nxt >= B_SLOT);
        slot_bit   = right_slot ? (bit_nxt - B_SLOT) : bit_nxt;
        slot_word  = right_slot ? act_r_nxt : act_l_nxt;
        shifted    = slot_word << slot_bit;
        sd_nxt     = shifted[DATAWIDTH-1];
        ws_nxt     = (bit_nxt >= WS_FIRST) && (bit_nxt <= WS_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt       <= DIV_LAST;
            bit_idx       <= B_LAST;
            act_l         <= '0;
            act_r         <= '0;
            pend_l        <= '0;
            pend_r        <= '0;
            pend_vld      <= 1'b0;
            underrun_cnt  <= '0;
            frame_start_o <= 1'b0;
            sck_o         <= 1'b0;
            ws_o          <= 1'b0;
            sd_o          <= 1'b0;
        end else begin
            div_cnt       <= div_nxt;
            bit_idx       <= bit_nxt;
            act_l         <= act_l_nxt;
            act_r         <= act_r_nxt;
            frame_start_o <= load;
            sck_o         <= en && (div_nxt >= DIV_HALF);

            if (accept) begin
                pend_l   <= s_l_data;
                pend_r   <= s_r_data;
                pend_vld <= 1'b1;
            end else if (load) begin
                pend_vld <= 1'b0;
            end

            if (load && !pend_vld && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end

            if (!en) begin
                ws_o <= 1'b0;
                sd_o <= 1'b0;
            end else if (fall_evt) begin
                ws_o <= ws_nxt;
                sd_o <= sd_nxt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_encoder.sv
// Directed bench for i2s_encoder: a Philips-format receiver model samples SD on SCK rise
// and the sequence checks reset, framing, backpressure, underrun, abort and a random stream.
module tb_i2s_encoder;

    localparam int DW        = 24;
    localparam int SB        = 32;
    localparam int DIV       = 20;
    localparam int FRAME_CYC = 2 * SB * DIV;

    logic          sys_clk;
    logic          sys_rst;
    logic          en;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_l_data;
    logic [DW-1:0] s_r_data;
    logic          sck_o;
    logic          ws_o;
    logic          sd_o;
    logic          frame_start_o;
    logic [15:0]   underrun_cnt;

    i2s_encoder #(.DATAWIDTH(DW), .SLOT_BITS(SB), .SCLK_DIV(DIV)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .en            (en),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_l_data      (s_l_data),
        .s_r_data      (s_r_data),
        .sck_o         (sck_o),
        .ws_o          (ws_o),
        .sd_o          (sd_o),
        .frame_start_o (frame_start_o),
        .underrun_cnt  (underrun_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Receiver model state
    logic [DW-1:0] rx_l[$];
    logic [DW-1:0] rx_r[$];
    logic [DW-1:0] word;
    logic          ws_d1, ws_d2, sck_d;
    int            bit_cnt, rise_idx, pad_ones;
    int            ws_rise_at = -1;
    int            ws_fall_at = -1;

    // The bit sampled at a rise belongs to the channel WS showed one rise earlier;
    // a WS change one rise earlier marks that bit as an MSB.
    always @(negedge sys_clk) begin
        if (sys_rst || !en) begin
            ws_d1   = 1'b0;
            ws_d2   = 1'b1;
            sck_d   = 1'b0;
            bit_cnt = 0;
        end else begin
            if (frame_start_o) rise_idx = 0;
            if (sck_o && !sck_d) begin
                if (ws_d1 != ws_d2) begin
                    bit_cnt = 0;
                    word    = '0;
                end
                if (bit_cnt < DW) begin
                    word[DW-1-bit_cnt] = sd_o;
                    if (bit_cnt == DW - 1) begin
                        if (ws_d1) rx_r.push_back(word);
                        else       rx_l.push_back(word);
                    end
                end else if (sd_o) begin
                    pad_ones++;
                end
                if (ws_o && !ws_d1) ws_rise_at = rise_idx;
                if (!ws_o && ws_d1) ws_fall_at = rise_idx;
                ws_d2 = ws_d1;
                ws_d1 = ws_o;
                rise_idx++;
                if (bit_cnt < 1000) bit_cnt++;
            end
            sck_d = sck_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_fs(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (!frame_start_o && cyc < max_cyc);
        check({tag, "_frame_start"}, frame_start_o, 1'b1);
    endtask

    // Presents a pair, waits for ready, lets it be taken on the next edge.
    task automatic send(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r);
        int cyc;
        s_l_data = l;
        s_r_data = r;
        s_valid  = 1'b1;
        cyc      = 0;
        while (!s_ready && cyc < 3000) begin
            step(1);
            cyc++;
        end
        check({tag, "_ready_seen"}, s_ready, 1'b1);
        step(1);
        s_valid = 1'b0;
        check({tag, "_ready_drop"}, s_ready, 1'b0);
    endtask

    task automatic pop_check(input string tag, input bit right, input logic [DW-1:0] exp);
        logic [DW-1:0] got;
        got = 'x;
        if (right && rx_r.size() > 0)       got = rx_r.pop_front();
        else if (!right && rx_l.size() > 0) got = rx_l.pop_front();
        check(tag, got, exp);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        en      = 1'b0;
        s_valid = 1'b0;
        step(2);
        sys_rst = 1'b0;
        step(1);
        rx_l.delete();
        rx_r.delete();
        pad_ones = 0;
    endtask

    logic [DW-1:0] bp_l[3] = '{24'h111111, 24'h222222, 24'h333333};
    logic [DW-1:0] bp_r[3] = '{24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC};
    logic [DW-1:0] rl[12];
    logic [DW-1:0] rr[12];

    initial begin
        int cyc;
        int falls;
        logic prev_sck;
        logic [DW-1:0] acc;

        // Reset with en and s_valid high: reset wins
        sys_rst  = 1'b1;
        en       = 1'b1;
        s_valid  = 1'b1;
        s_l_data = 24'h123456;
        s_r_data = 24'h654321;
        step(3);
        check("rst_sck", sck_o, 1'b0);
        check("rst_ws", ws_o, 1'b0);
        check("rst_sd", sd_o, 1'b0);
        check("rst_ready", s_ready, 1'b1);
        check("rst_fs", frame_start_o, 1'b0);
        check("rst_underrun", underrun_cnt, 16'd0);
        sys_rst = 1'b0;
        s_valid = 1'b0;
        wait_fs("rst_release", 5, cyc);
        check("rst_fs_latency", cyc, 1);
        cyc = 0;
        while (!sck_o && cyc < 50) begin
            step(1);
            cyc++;
        end
        check("sck_first_rise", cyc, DIV / 2);
        cyc = 0;
        do begin step(1); cyc++; end while (sck_o && cyc < 50);
        do begin step(1); cyc++; end while (!sck_o && cyc < 100);
        check("sck_period", cyc, DIV);
        check("rst_first_underrun", underrun_cnt, 16'd1);

        // Single frame
        do_reset();
        send("sf", 24'hA5A5A5, 24'h5A5A5A);
        en = 1'b1;
        wait_fs("sf_1", 5, cyc);
        check("sf_fs_latency", cyc, 1);
        check("sf_ready_back", s_ready, 1'b1);
        check("sf_underrun0", underrun_cnt, 16'd0);
        wait_fs("sf_2", FRAME_CYC + 10, cyc);
        check("sf_frame_len", cyc, FRAME_CYC);
        pop_check("sf_left", 1'b0, 24'hA5A5A5);
        pop_check("sf_right", 1'b1, 24'h5A5A5A);
        check("sf_ws_rise_bit", ws_rise_at, 31);
        check("sf_ws_fall_bit", ws_fall_at, 63);
        check("sf_pad_zero", pad_ones, 0);
        check("sf_underrun1", underrun_cnt, 16'd1);

        // Backpressure: first accept coincides with the first load
        do_reset();
        en = 1'b1;
        send("bp0", bp_l[0], bp_r[0]);
        check("bp_coincident_fs", frame_start_o, 1'b1);
        check("bp_coincident_underrun", underrun_cnt, 16'd1);
        step(600);
        check("bp_hold_low", s_ready, 1'b0);
        send("bp1", bp_l[1], bp_r[1]);
        send("bp2", bp_l[2], bp_r[2]);
        check("bp_underrun_mid", underrun_cnt, 16'd1);
        wait_fs("bp_f4", FRAME_CYC + 10, cyc);
        check("bp_underrun_f4", underrun_cnt, 16'd1);
        wait_fs("bp_f5", FRAME_CYC + 10, cyc);
        check("bp_underrun_f5", underrun_cnt, 16'd2);
        pop_check("bp_l_silence", 1'b0, '0);
        pop_check("bp_r_silence", 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            pop_check($sformatf("bp_l%0d", i), 1'b0, bp_l[i]);
            pop_check($sformatf("bp_r%0d", i), 1'b1, bp_r[i]);
        end

        // Underrun and saturation
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) wait_fs($sformatf("ur_f%0d", i), FRAME_CYC + 10, cyc);
        check("ur_count5", underrun_cnt, 16'd5);
        check("ur_words", rx_l.size() + rx_r.size(), 8);
        acc = '0;
        foreach (rx_l[i]) acc |= rx_l[i];
        foreach (rx_r[i]) acc |= rx_r[i];
        check("ur_silence", acc, '0);
        en = 1'b0;
        step(2);
        force dut.underrun_cnt = 16'hFFFE;
        step(1);
        release dut.underrun_cnt;
        step(3);
        check("ur_idle_retain", underrun_cnt, 16'hFFFE);
        en = 1'b1;
        wait_fs("sat_1", 5, cyc);
        check("sat_reach", underrun_cnt, 16'hFFFF);
        wait_fs("sat_2", FRAME_CYC + 10, cyc);
        wait_fs("sat_3", FRAME_CYC + 10, cyc);
        check("sat_hold", underrun_cnt, 16'hFFFF);

        // Mid-frame abort at bit 10, restart plays the pending pair
        do_reset();
        send("ab_a", 24'hFFFFFF, 24'hFFFFFF);
        en = 1'b1;
        wait_fs("ab_1", 5, cyc);
        send("ab_b", 24'hC3C3C3, 24'h3C3C3C);
        falls    = 0;
        cyc      = 0;
        prev_sck = sck_o;
        while (falls < 10 && cyc < 2000) begin
            step(1);
            cyc++;
            if (prev_sck && !sck_o) falls++;
            prev_sck = sck_o;
        end
        step(12);
        check("ab_pre_sck", sck_o, 1'b1);
        check("ab_pre_sd", sd_o, 1'b1);
        en = 1'b0;
        step(1);
        check("ab_sck", sck_o, 1'b0);
        check("ab_ws", ws_o, 1'b0);
        check("ab_sd", sd_o, 1'b0);
        step(3);
        rx_l.delete();
        rx_r.delete();
        en = 1'b1;
        wait_fs("ab_restart", 5, cyc);
        check("ab_restart_latency", cyc, 1);
        check("ab_underrun", underrun_cnt, 16'd0);
        wait_fs("ab_2", FRAME_CYC + 10, cyc);
        pop_check("ab_left", 1'b0, 24'hC3C3C3);
        pop_check("ab_right", 1'b1, 24'h3C3C3C);

        // Random stream through the receiver model
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rl[i] = DW'($urandom);
            rr[i] = DW'($urandom);
        end
        send("rnd0", rl[0], rr[0]);
        en = 1'b1;
        for (int i = 1; i < 12; i++) send($sformatf("rnd%0d", i), rl[i], rr[i]);
        wait_fs("rnd_f12", FRAME_CYC + 10, cyc);
        wait_fs("rnd_f13", FRAME_CYC + 10, cyc);
        for (int i = 0; i < 12; i++) begin
            pop_check($sformatf("rnd_l%0d", i), 1'b0, rl[i]);
            pop_check($sformatf("rnd_r%0d", i), 1'b1, rr[i]);
        end
        check("rnd_underrun", underrun_cnt, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
